// File: rtl/alarm_pkg.sv
// Shared time types and helpers for the alarm scheduler: 12/24-hour conversion,
// input range check and scheduler FSM states.
package alarm_pkg;

  typedef logic [4:0] hour24_t;
  typedef logic [3:0] hour12_t;
  typedef logic [5:0] min_t;
  typedef logic [5:0] sec_t;

  typedef struct packed {
    hour24_t h;
    min_t    m;
    sec_t    s;
  } tstamp_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PRESENT} state_e;

  localparam hour24_t MAX_H = 5'd23;
  localparam min_t    MAX_M = 6'd59;
  localparam sec_t    MAX_S = 6'd59;

  // 12 AM is midnight, 12 PM is noon
  function automatic hour24_t to_h24(hour12_t h12, logic pm);
    if (h12 == 4'd12) return pm ? 5'd12 : 5'd0;
    return pm ? hour24_t'(h12) + 5'd12 : hour24_t'(h12);
  endfunction

  function automatic logic range_ok(hour12_t h12, min_t m, sec_t s);
    return (h12 >= 4'd1) && (h12 <= 4'd12) && (m <= MAX_M) && (s <= MAX_S);
  endfunction

endpackage

// File: rtl/tod_counter.sv
// 24-hour h:m:s counter with synchronous load; load has priority over tick.
module tod_counter
  import alarm_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    tick_i,
  input  logic    load_i,
  input  tstamp_t load_val_i,
  output tstamp_t tod_o
);

  tstamp_t tod_q, tod_d;

  always_comb begin
    tod_d = tod_q;
    if (load_i) begin
      tod_d = load_val_i;
    end else if (tick_i) begin
      if (tod_q.s == MAX_S) begin
        tod_d.s = '0;
        if (tod_q.m == MAX_M) begin
          tod_d.m = '0;
          tod_d.h = (tod_q.h == MAX_H) ? '0 : tod_q.h + 5'd1;
        end else begin
          tod_d.m = tod_q.m + 6'd1;
        end
      end else begin
        tod_d.s = tod_q.s + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tod_q <= '0;
    else        tod_q <= tod_d;

  assign tod_o = tod_q;

endmodule

// File: rtl/alarm_scheduler.sv
// Time-of-day keeper with N_ALARMS slots scanned by one shared comparator after each
// second rollover to :00. Define ALARM_SNOOZE_EN to add the snooze input and slot.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick_1hz,
  input  logic                        set_time,
  input  logic [3:0]                  set_h12,
  input  logic                        set_pm,
  input  logic [5:0]                  set_m,
  input  logic [5:0]                  set_s,
  input  logic                        alm_wr,
  input  logic [$clog2(N_ALARMS)-1:0] alm_idx,
  input  logic [3:0]                  alm_h12,
  input  logic                        alm_pm,
  input  logic [5:0]                  alm_m,
  input  logic                        alm_en,
  input  logic                        alarm_ack,
`ifdef ALARM_SNOOZE_EN
  input  logic                        snooze,
`endif
  output logic [4:0]                  cur_h,
  output logic [5:0]                  cur_m,
  output logic [5:0]                  cur_s,
  output logic                        alarm_fire,
  output logic [$clog2(N_ALARMS)-1:0] alarm_id,
  output logic                        busy,
  output logic                        cfg_err
);

  localparam int IW = $clog2(N_ALARMS);
`ifdef ALARM_SNOOZE_EN
  localparam int SCAN_LEN = N_ALARMS + 1;
`else
  localparam int SCAN_LEN = N_ALARMS;
`endif
  localparam int PW = $clog2(SCAN_LEN);
  localparam logic [PW-1:0] LAST_PTR = PW'(SCAN_LEN - 1);

  if (N_ALARMS < 2 || N_ALARMS > 16 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_cfg
    $error("alarm_scheduler: parameter out of range");
  end

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [N_ALARMS-1:0] pend_q, pend_d;
  hour24_t             slot_h_q [N_ALARMS];
  min_t                slot_m_q [N_ALARMS];
  logic [N_ALARMS-1:0] slot_en_q;
  logic                tick_q, cfg_err_q;
  tstamp_t             tod, set_ts, cmp_ts;
  logic                set_ok, load, wr_ok, trig, ack_ok, cmp_hit, clr_pres;
  logic [IW-1:0]       slot_sel, pres_id;

  assign set_ok = range_ok(set_h12, set_m, set_s);
  assign load   = set_time && set_ok;
  assign wr_ok  = alm_wr && range_ok(alm_h12, alm_m, '0) && (32'(alm_idx) < N_ALARMS);
  assign set_ts = '{h: to_h24(set_h12, set_pm), m: set_m, s: set_s};

  tod_counter u_tod (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_i    (tick_1hz && !load),
    .load_i    (load),
    .load_val_i(set_ts),
    .tod_o     (tod)
  );

  // Scan only follows a tick that actually advanced the clock onto a whole minute
  assign trig     = tick_q && (tod.s == '0);
  assign slot_sel = ptr_q[IW-1:0];
  assign cmp_ts   = '{h: slot_h_q[slot_sel], m: slot_m_q[slot_sel], s: '0};
  assign cmp_hit  = (state_q == S_SCAN) && !load && (32'(ptr_q) < N_ALARMS)
                    && slot_en_q[slot_sel] && (cmp_ts == tod);
  assign ack_ok   = alarm_ack && (|pend_q);

  always_comb begin
    pres_id = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--)
      if (pend_q[i]) pres_id = IW'(i);
  end

`ifdef ALARM_SNOOZE_EN
  tstamp_t       snz_q, snz_d;
  logic          snz_vld_q, snz_vld_d, snz_go, snz_hit;
  logic [IW-1:0] snz_id_q, snz_id_d;
  logic [6:0]    msum;

  assign snz_go   = snooze && (|pend_q);
  assign snz_hit  = (state_q == S_SCAN) && !load && (32'(ptr_q) == N_ALARMS)
                    && snz_vld_q && (snz_q == tod);
  assign msum     = 7'(tod.m) + 7'(SNOOZE_MIN);
  assign clr_pres = ack_ok || snz_go;

  always_comb begin
    snz_d     = snz_q;
    snz_id_d  = snz_id_q;
    snz_vld_d = snz_vld_q && !snz_hit;
    if (snz_go) begin
      snz_vld_d = 1'b1;
      snz_id_d  = pres_id;
      snz_d.s   = '0;
      snz_d.m   = (msum >= 7'd60) ? min_t'(msum - 7'd60) : min_t'(msum);
      snz_d.h   = (msum < 7'd60) ? tod.h : (tod.h == MAX_H) ? '0 : tod.h + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      snz_q     <= '0;
      snz_vld_q <= 1'b0;
      snz_id_q  <= '0;
    end else begin
      snz_q     <= snz_d;
      snz_vld_q <= snz_vld_d;
      snz_id_q  <= snz_id_d;
    end
`else
  assign clr_pres = ack_ok;
`endif

  always_comb begin
    pend_d = pend_q;
    if (cmp_hit) pend_d[slot_sel] = 1'b1;
`ifdef ALARM_SNOOZE_EN
    if (snz_hit) pend_d[snz_id_q] = 1'b1;
`endif
    if (clr_pres) pend_d[pres_id] = 1'b0;
    // A rewritten slot must not keep firing with its stale match
    if (wr_ok) pend_d[alm_idx] = 1'b0;

    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_SCAN;
          ptr_d   = '0;
        end else if (|pend_d) begin
          state_d = S_PRESENT;
        end
      end
      S_SCAN: begin
        ptr_d = ptr_q + 1'b1;
        if (load || ptr_q == LAST_PTR) state_d = (|pend_d) ? S_PRESENT : S_IDLE;
      end
      S_PRESENT: begin
        if (trig) begin
          state_d = S_SCAN;
          ptr_d   = '0;
        end else if (!(|pend_d)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      pend_q    <= '0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pend_q    <= pend_d;
      tick_q    <= tick_1hz && !load;
      cfg_err_q <= (set_time && !set_ok) || (alm_wr && !range_ok(alm_h12, alm_m, '0));
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        slot_h_q[i] <= '0;
        slot_m_q[i] <= '0;
      end
      slot_en_q <= '0;
    end else if (wr_ok) begin
      slot_h_q[alm_idx]  <= to_h24(alm_h12, alm_pm);
      slot_m_q[alm_idx]  <= alm_m;
      slot_en_q[alm_idx] <= alm_en;
    end

  assign cur_h      = tod.h;
  assign cur_m      = tod.m;
  assign cur_s      = tod.s;
  assign alarm_fire = |pend_q;
  assign alarm_id   = pres_id;
  assign busy       = (state_q == S_SCAN);
  assign cfg_err    = cfg_err_q;

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
- Time-of-day keeper plus multi-slot alarm scheduler.
- Holds current time in 24-hour format. Alarm slots are programmed in 12-hour + PM form and converted to 24-hour at write.
- After every second tick, one shared 17-bit time equality comparator is time-multiplexed across all slots, one slot per cycle.
- Matching alarms are queued and presented one at a time to the user-interface/buzzer logic under a fire/ack handshake.

Parameters:
- N_ALARMS, 4, number of alarm slots (2..16).
- SNOOZE_MIN, 5, snooze delay in minutes (1..59). Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle pulse per second; spacing guaranteed >= N_ALARMS+3 cycles
- set_time  in  1  load current time this cycle
- set_h12  in  4  hour 1..12 for set_time
- set_pm  in  1  PM flag for set_time
- set_m  in  6  minute 0..59
- set_s  in  6  second 0..59
- alm_wr  in  1  write alarm slot
- alm_idx  in  clog2(N_ALARMS)  slot index
- alm_h12  in  4  alarm hour 1..12
- alm_pm  in  1  alarm PM flag
- alm_m  in  6  alarm minute
- alm_en  in  1  slot enable bit written with slot
- alarm_ack  in  1  acknowledges the presented alarm
- cur_h  out  5  current hour 0..23
- cur_m  out  6  current minute
- cur_s  out  6  current second
- alarm_fire  out  1  level; an alarm is presented
- alarm_id  out  clog2(N_ALARMS)  index of presented alarm
- busy  out  1  scan in progress
- cfg_err  out  1  one-cycle pulse: out-of-range set_time/alm_wr rejected

Behaviour:
- Reset:
  - Time is 00:00:00. All slots are 00:00 and disabled.
  - Pending mask is 0. FSM is IDLE.
  - alarm_fire, alarm_id, busy and cfg_err are all 0.
- 12-to-24 conversion:
  - 12 AM -> 0; 12 PM -> 12.
  - Other hours: PM adds 12, AM passes through.
- Range check: h12 must be 1..12, m/s must be 0..59. A violating write is discarded and cfg_err pulses on the next cycle.
- Time counter:
  - On tick_1hz, seconds increment, carrying into minutes and then hours.
  - 23:59:59 wraps to 00:00:00.
  - cur_* is registered and updates 1 cycle after the tick.
- set_time:
  - Loads converted time 1 cycle later.
  - set_time and tick in the same cycle: set_time wins and the tick is dropped.
- FSM states: IDLE, SCAN, PRESENT.
  - IDLE -> SCAN: on the cycle after a time update caused by tick, only when the new cur_s == 0. Scan pointer starts at 0.
  - SCAN: each cycle compares slot[ptr] {h,m,6'd0} against {cur_h,cur_m,cur_s}. If equal and the slot is enabled, the pending bit is set. ptr increments.
  - SCAN end: after ptr = N_ALARMS-1, go to PRESENT if pending != 0, else IDLE. busy=1 throughout SCAN.
  - PRESENT:
    - alarm_fire=1 and alarm_id = lowest pending index.
    - alarm_ack clears that bit. The next pending alarm is presented on the following cycle. When none remain, alarm_fire deasserts and the FSM returns to IDLE.
    - Ack while alarm_fire=0 is ignored.
    - A new scan trigger in PRESENT is still taken; scanning adds to pending while presentation continues.
- set_time during SCAN: the scan aborts to IDLE (or to PRESENT if pending != 0). The pending mask is kept.
- alm_wr:
  - Applied at cycle end. A slot compared in the same cycle uses the old value.
  - Writing a slot clears its pending bit. If that slot is being presented, alarm_fire drops the next cycle or moves to the next pending alarm.
- Latency: match at tick t reaches alarm_fire by t + 2 + idx + 1 cycles.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Enabled:
  - Adds input snooze (1 bit), valid only while alarm_fire=1.
  - snooze clears the presented pending bit and loads a single snooze register with cur time + SNOOZE_MIN minutes, wrapping at 24:00. A later snooze overwrites it.
  - The snooze register is scanned as extra slot N_ALARMS. Its match is reported with alarm_id = the original slot and self-clears.
  - snooze and alarm_ack in the same cycle: snooze wins.
- Disabled: the port and register are absent, and the scan length is exactly N_ALARMS.

Decomposition:
- Package alarm_pkg:
  - Typedefs hour24_t (5b), hour12_t (4b), min_t/sec_t (6b), tstamp_t (17b packed h,m,s).
  - Constants for the max hour/minute/second values.
  - Function to_h24(h12, pm) and function range_ok.
- Sub-module tod_counter: the h/m/s counter with load and wrap. The scheduler FSM, slot RAM and comparator stay in the top level.

Test Plan:
- Set 11 PM 59:58, two ticks -> cur 23:59:59, then 00:00:00; no alarm fires (all slots disabled).
- Slot 2 = 7:30 AM enabled; set 7:29:59 AM, tick -> cur 07:30:00, busy for 4 cycles, alarm_fire=1 with id=2; ack -> fire=0, FSM IDLE.
- Slots 1 and 3 both 12:00 AM; wrap from 23:59:59 -> id=1 presented first; ack -> id=3 the next cycle; ack -> fire=0.
- set_h12=13 or alm_m=60 -> cfg_err pulse, state unchanged; set_time in same cycle as tick -> loaded time shown, tick ignored.
- set_time asserted mid-scan -> busy drops the next cycle, no new pending; alm_wr to the presented slot -> fire moves to the next pending alarm or clears.
- With ALARM_SNOOZE_EN: slot 0 fires at 06:00, snooze -> slot 0 re-fires at 06:05:00 with id=0; snooze at 23:58 -> re-fires at 00:03.
